// File: rtl/counter_pkg.sv
// counter_pkg: shared types, mode constants and index-width helper for the strobe counter bank
package counter_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  function automatic int ch_idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/counter_strobe_channel.sv
// counter_strobe_channel: one shadowed periodic/one-shot strobe counter
module counter_strobe_channel import counter_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_period,
  input  logic             wr_oneshot,
  input  logic             start,
  input  logic             stop,
  output logic             strobe,
  output logic             running
);
  ch_state_e state;
  logic [WIDTH-1:0] count, act_period, sh_period, sh_period_n;
  logic act_mode, sh_mode, sh_mode_n, run, hit, load;
  // same-cycle write forwarding, hit detection and active-register load condition
  always_comb begin
    sh_period_n = wr ? wr_period : sh_period;
    sh_mode_n = wr ? wr_oneshot : sh_mode;
    run = state == RUN;
    hit = run && tick && count == act_period;
    load = !run || hit || start;
  end
  assign running = run;
  // registers: stop beats start beats hit beats counting; writes always land in shadow
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      count <= WIDTH'(1);
      act_period <= '0;
      sh_period <= '0;
      act_mode <= MODE_PERIODIC;
      sh_mode <= MODE_PERIODIC;
      strobe <= 1'b0;
    end else begin
      sh_period <= sh_period_n;
      sh_mode <= sh_mode_n;
      if (load) begin
        act_period <= sh_period_n;
        act_mode <= sh_mode_n;
      end
      strobe <= hit && !start && !stop;
      if (stop) begin
        state <= IDLE;
        count <= WIDTH'(1);
      end else if (start) begin
        state <= (sh_period_n != '0) ? RUN : IDLE;
        count <= WIDTH'(1);
      end else if (hit) begin
        state <= (sh_mode_n == MODE_ONESHOT || sh_period_n == '0) ? IDLE : RUN;
        count <= WIDTH'(1);
      end else if (run && tick) begin
        count <= count + 1'b1;
      end
    end
endmodule

// File: rtl/counter_strobe_bank.sv
// counter_strobe_bank: CHANNELS strobe counters on one tick; COUNTER_STROBE_BANK_PRESCALE_EN adds a shared tick prescaler
module counter_strobe_bank import counter_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tick,
  input  logic                            wr_en,
  input  logic [ch_idx_w(CHANNELS)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]                wr_period,
  input  logic                            wr_oneshot,
  input  logic [CHANNELS-1:0]             start,
  input  logic [CHANNELS-1:0]             stop,
  output logic [CHANNELS-1:0]             strobe,
  output logic [CHANNELS-1:0]             running
);
  localparam int IW = ch_idx_w(CHANNELS);
  logic ptick;
`ifdef COUNTER_STROBE_BANK_PRESCALE_EN
  logic [WIDTH-1:0] pre;
  assign ptick = tick && pre == WIDTH'(PRESCALE - 1);
  // free-running tick divider, independent of channel start/stop
  always_ff @(posedge clk or negedge rst)
    if (!rst) pre <= '0;
    else if (tick) pre <= ptick ? '0 : pre + 1'b1;
`else
  assign ptick = tick;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    counter_strobe_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (ptick),
      .wr         (wr_en && wr_ch == IW'(c)),
      .wr_period  (wr_period),
      .wr_oneshot (wr_oneshot),
      .start      (start[c]),
      .stop       (stop[c]),
      .strobe     (strobe[c]),
      .running    (running[c])
    );
  end
endmodule
